regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_pkg.sv | 6 +
 rtl/regfile_init_seq.sv | 35 +++
 rtl/regfile_mp.sv | 64 ++++++
 tb/tb_regfile_mp.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared controller state encoding and default sizing for the register file.
package regfile_pkg;
   typedef enum logic {INIT, READY} state_t;
   localparam int N_DEF = 64;
   localparam int ADDR_W_DEF = 5;
endpackage

// File: rtl/regfile_init_seq.sv
// regfile_init_seq: after reset, sweeps X[i] <= i over every register but the zero register, then raises ready.
module regfile_init_seq
   import regfile_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   output logic              ready,
   output logic              init_we,
   output logic [ADDR_W-1:0] init_wa,
   output logic [N-1:0]      init_wd
);
   // The sweep ends on NREG-2; the zero register is never stored.
   localparam logic [ADDR_W-1:0] LAST = {{(ADDR_W-1){1'b1}}, 1'b0};
   state_t state;
   logic [ADDR_W-1:0] cnt;
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= INIT;
         cnt   <= '0;
         ready <= 1'b0;
      end else if (state == INIT) begin
         cnt <= cnt + 1'b1;
         if (cnt == LAST) begin
            state <= READY;
            ready <= 1'b1;
         end
      end
   end
   assign init_we = reset && state == INIT;
   assign init_wa = cnt;
   assign init_wd = N'(cnt);
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file, NRD async read ports and two write ports (port 1 wins),
// hard-wired zero in the top register, optional write-to-read forwarding, self-initialising after reset.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int NRD = 2,
   parameter int BYPASS = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NRD*ADDR_W-1:0] ra,
   output logic [NRD*N-1:0]      rd,
   input  logic [1:0]            we,
   input  logic [2*ADDR_W-1:0]   wa,
   input  logic [2*N-1:0]        wd,
   output logic                  ready
);
   localparam int NREG = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] ZR = '1;
   logic [N-1:0] mem [NREG];
   logic init_we;
   logic [ADDR_W-1:0] init_wa;
   logic [N-1:0] init_wd;
   logic [1:0] wen;
   logic [ADDR_W-1:0] a;
   logic [N-1:0] v;
   regfile_init_seq #(.N(N), .ADDR_W(ADDR_W)) u_init (
      .clk(clk),
      .reset(reset),
      .ready(ready),
      .init_we(init_we),
      .init_wa(init_wa),
      .init_wd(init_wd)
   );
   always_comb begin
      wen = '0;
      for (int k = 0; k < 2; k++)
         wen[k] = ready && we[k] && wa[k*ADDR_W +: ADDR_W] != ZR;
   end
   // Port 1 is applied last so it wins an address collision.
   always_ff @(posedge clk) begin
      if (!ready) begin
         if (init_we) mem[init_wa] <= init_wd;
      end else begin
         for (int k = 0; k < 2; k++)
            if (wen[k]) mem[wa[k*ADDR_W +: ADDR_W]] <= wd[k*N +: N];
      end
   end
   always_comb begin
      rd = '0;
      a  = '0;
      v  = '0;
      for (int p = 0; p < NRD; p++) begin
         a = ra[p*ADDR_W +: ADDR_W];
         v = mem[a];
         if (BYPASS != 0)
            for (int k = 0; k < 2; k++)
               if (wen[k] && wa[k*ADDR_W +: ADDR_W] == a) v = wd[k*N +: N];
         rd[p*N +: N] = (!ready || a == ZR) ? '0 : v;
      end
   end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: drives a forwarding and a non-forwarding build side by side and checks both
// against a plain array model of the register file.
module tb_regfile_mp;
   localparam int N = 32, AW = 5, NRD = 3, NREG = 32, ZR = 31;
   logic clk = 0, reset = 0;
   logic [NRD*AW-1:0] ra = '0;
   logic [NRD*N-1:0] rd, rd_nb;
   logic [1:0] we = '0;
   logic [2*AW-1:0] wa = '0;
   logic [2*N-1:0] wd = '0;
   logic ready, ready_nb;
   int checks = 0, failures = 0;
   logic [N-1:0] model [NREG];
   bit mready = 0;

   regfile_mp #(.N(N), .ADDR_W(AW), .NRD(NRD), .BYPASS(1)) dut (
      .clk(clk), .reset(reset), .ra(ra), .rd(rd), .we(we), .wa(wa), .wd(wd), .ready(ready));
   regfile_mp #(.N(N), .ADDR_W(AW), .NRD(NRD), .BYPASS(0)) dut_nb (
      .clk(clk), .reset(reset), .ra(ra), .rd(rd_nb), .we(we), .wa(wa), .wd(wd), .ready(ready_nb));

   always #5 clk = ~clk;

   function automatic logic [N-1:0] exp_rd(int p, bit byp);
      int a = int'(ra[p*AW +: AW]);
      logic [N-1:0] v;
      if (!mready || a == ZR) return '0;
      v = model[a];
      if (byp && we[1] && int'(wa[2*AW-1:AW]) == a) return wd[2*N-1:N];
      if (byp && we[0] && int'(wa[AW-1:0]) == a) return wd[N-1:0];
      return v;
   endfunction

   function automatic logic [AW-1:0] rnd_addr();
      int s = $urandom_range(0, 9);
      if (s == 0) return AW'(ZR);
      if (s < 5) return AW'($urandom_range(0, 7));
      return AW'($urandom_range(0, NREG-1));
   endfunction

   task automatic tick();
      @(posedge clk);
      if (mready) begin
         if (we[0] && int'(wa[AW-1:0]) != ZR) model[wa[AW-1:0]] = wd[N-1:0];
         if (we[1] && int'(wa[2*AW-1:AW]) != ZR) model[wa[2*AW-1:AW]] = wd[2*N-1:N];
      end
      #1;
   endtask

   task automatic rebuild_model();
      for (int i = 0; i < NREG; i++) model[i] = (i == ZR) ? '0 : N'(i);
      mready = 1;
   endtask

   task automatic test_reset();
      int edges;
      reset = 0;
      ra = {5'd0, 5'd31, 5'd7};
      repeat (2) tick();
      checks++;
      if (ready !== 1'b0 || ready_nb !== 1'b0) begin
         failures++;
         $display("FAIL reset_ready ready=%b/%b expected 0", ready, ready_nb);
      end
      reset = 1;
      edges = 0;
      while (!ready && edges < 100) begin
         checks++;
         if (rd !== '0 || rd_nb !== '0) begin
            failures++;
            $display("FAIL init_rd_zero edge=%0d rd=%h rd_nb=%h expected 0", edges, rd, rd_nb);
         end
         tick();
         edges++;
      end
      checks++;
      if (edges !== 31) begin
         failures++;
         $display("FAIL init_edges got=%0d expected 31", edges);
      end
      checks++;
      if (ready_nb !== 1'b1) begin
         failures++;
         $display("FAIL ready_nb got=%b expected 1", ready_nb);
      end
      rebuild_model();
      checks++;
      if (rd !== {32'd0, 32'd0, 32'd7} || rd_nb !== {32'd0, 32'd0, 32'd7}) begin
         failures++;
         $display("FAIL post_init_read rd=%h rd_nb=%h expected %h", rd, rd_nb, {32'd0, 32'd0, 32'd7});
      end
   endtask

   task automatic test_bypass();
      we = 2'b01;
      wa = {5'd0, 5'd3};
      wd = {32'd0, 32'hDEAD};
      ra = {5'd0, 5'd0, 5'd3};
      #1;
      checks++;
      if (rd[N-1:0] !== 32'hDEAD) begin
         failures++;
         $display("FAIL bypass_same_cycle rd0=%h expected %h", rd[N-1:0], 32'hDEAD);
      end
      checks++;
      if (rd_nb[N-1:0] !== 32'd3) begin
         failures++;
         $display("FAIL nobypass_same_cycle rd0=%h expected %h", rd_nb[N-1:0], 32'd3);
      end
      tick();
      we = 2'b00;
      #1;
      checks++;
      if (rd[N-1:0] !== 32'hDEAD || rd_nb[N-1:0] !== 32'hDEAD) begin
         failures++;
         $display("FAIL write_commit rd0=%h rd0_nb=%h expected %h", rd[N-1:0], rd_nb[N-1:0], 32'hDEAD);
      end
   endtask

   task automatic test_same_addr();
      we = 2'b11;
      wa = {5'd5, 5'd5};
      wd = {32'h22, 32'h11};
      ra = {5'd0, 5'd0, 5'd5};
      #1;
      checks++;
      if (rd[N-1:0] !== 32'h22 || rd_nb[N-1:0] !== 32'd5) begin
         failures++;
         $display("FAIL collide_same_cycle rd0=%h rd0_nb=%h expected 22/5", rd[N-1:0], rd_nb[N-1:0]);
      end
      tick();
      we = 2'b00;
      #1;
      checks++;
      if (rd[N-1:0] !== 32'h22 || rd_nb[N-1:0] !== 32'h22) begin
         failures++;
         $display("FAIL collide_commit rd0=%h rd0_nb=%h expected 22", rd[N-1:0], rd_nb[N-1:0]);
      end
   endtask

   task automatic test_zero_reg();
      we = 2'b01;
      wa = {5'd0, 5'd31};
      wd = {32'd0, 32'hFF};
      ra = {5'd31, 5'd31, 5'd31};
      #1;
      checks++;
      if (rd !== '0 || rd_nb !== '0) begin
         failures++;
         $display("FAIL zr_same_cycle rd=%h rd_nb=%h expected 0", rd, rd_nb);
      end
      tick();
      we = 2'b00;
      #1;
      checks++;
      if (rd !== '0 || rd_nb !== '0) begin
         failures++;
         $display("FAIL zr_after rd=%h rd_nb=%h expected 0", rd, rd_nb);
      end
   endtask

   task automatic test_mid_init_reset();
      int edges;
      we = 2'b01;
      wa = {5'd0, 5'd4};
      wd = {32'd0, 32'h99};
      ra = {5'd0, 5'd0, 5'd4};
      tick();
      we = 2'b00;
      #1;
      checks++;
      if (rd[N-1:0] !== 32'h99 || rd_nb[N-1:0] !== 32'h99) begin
         failures++;
         $display("FAIL pre_reset_write rd0=%h rd0_nb=%h expected 99", rd[N-1:0], rd_nb[N-1:0]);
      end
      reset = 0;
      mready = 0;
      tick();
      reset = 1;
      repeat (10) tick();
      checks++;
      if (ready !== 1'b0 || rd !== '0) begin
         failures++;
         $display("FAIL mid_init_state ready=%b rd=%h expected 0/0", ready, rd);
      end
      reset = 0;
      we = 2'b11;
      wa = {5'd4, 5'd4};
      wd = {32'h55, 32'h66};
      tick();
      reset = 1;
      edges = 0;
      while (!ready && edges < 100) begin
         tick();
         edges++;
      end
      we = 2'b00;
      checks++;
      if (edges !== 31) begin
         failures++;
         $display("FAIL reinit_edges got=%0d expected 31", edges);
      end
      rebuild_model();
      #1;
      checks++;
      if (rd[N-1:0] !== 32'd4 || rd_nb[N-1:0] !== 32'd4) begin
         failures++;
         $display("FAIL reinit_x4 rd0=%h rd0_nb=%h expected 4", rd[N-1:0], rd_nb[N-1:0]);
      end
   endtask

   task automatic test_random();
      logic [N-1:0] e;
      for (int c = 0; c < 10000; c++) begin
         we = 2'($urandom_range(0, 3));
         wa = {rnd_addr(), rnd_addr()};
         wd = {$urandom(), $urandom()};
         for (int p = 0; p < NRD; p++) ra[p*AW +: AW] = rnd_addr();
         #1;
         checks++;
         if (ready !== 1'b1) begin
            failures++;
            $display("FAIL rand_ready cycle=%0d got=%b expected 1", c, ready);
         end
         for (int p = 0; p < NRD; p++) begin
            e = exp_rd(p, 1);
            checks++;
            if (rd[p*N +: N] !== e) begin
               failures++;
               $display("FAIL rand_bypass cycle=%0d port=%0d got=%h expected %h", c, p, rd[p*N +: N], e);
            end
            e = exp_rd(p, 0);
            checks++;
            if (rd_nb[p*N +: N] !== e) begin
               failures++;
               $display("FAIL rand_nobypass cycle=%0d port=%0d got=%h expected %h", c, p, rd_nb[p*N +: N], e);
            end
         end
         tick();
      end
      we = 2'b00;
   endtask

   initial begin
      test_reset();
      test_bypass();
      test_same_addr();
      test_zero_reg();
      test_mid_init_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
